// File: rtl/jk_reg_bank_pkg.sv
// jk_reg_bank shared types: JK opcode encoding and per-bit next-state rule.
// Optional edge outputs are enabled with JK_REG_BANK_EDGE_EN.
package jk_reg_bank_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  function automatic logic jk_next(
    input logic q,
    input logic j,
    input logic k
  );
    logic   r;
    jk_op_e op;
    op = jk_op_e'({j, k});
    r  = q;
    unique case (op)
      JK_HOLD:   r = q;
      JK_RESET:  r = 1'b0;
      JK_SET:    r = 1'b1;
      JK_TOGGLE: r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_reg_bank_if.sv
// Command and readback port bundle for jk_reg_bank.
// master drives commands/reads, slave returns readback data.
interface jk_reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int CHW   = 2
);
  logic             cmd_valid;
  logic [CHW-1:0]   cmd_ch;
  logic [WIDTH-1:0] cmd_j;
  logic [WIDTH-1:0] cmd_k;
  logic             rd_en;
  logic [CHW-1:0]   rd_ch;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] rd_chg;

  modport master (
    output cmd_valid, cmd_ch, cmd_j, cmd_k,
    output rd_en, rd_ch,
    input  rd_valid, rd_data, rd_chg
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_j, cmd_k,
    input  rd_en, rd_ch,
    output rd_valid, rd_data, rd_chg
  );
endinterface

// File: rtl/jk_reg_channel.sv
// One WIDTH-bit JK channel with sticky change flags.
// JK_REG_BANK_EDGE_EN adds registered rise/fall pulses.
module jk_reg_channel
  import jk_reg_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             rd_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] chg
`ifdef JK_REG_BANK_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] diff;

  always_comb begin
    q_nxt = q;
    for (int i = 0; i < WIDTH; i++) begin
      if (wr_sel) q_nxt[i] = jk_next(q[i], j[i], k[i]);
    end
  end

  assign diff = q_nxt ^ q;

  // a read clears old flags, but changes landing this edge survive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= RST_VAL;
      chg <= '0;
    end else begin
      q   <= q_nxt;
      chg <= (rd_clr ? '0 : chg) | diff;
    end
  end

`ifdef JK_REG_BANK_EDGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= q_nxt & ~q;
      fall <= ~q_nxt & q;
    end
  end
`endif

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of CH JK channels with command decode and registered readback.
// Define JK_REG_BANK_EDGE_EN to add rise/fall edge outputs.
module jk_reg_bank
  import jk_reg_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CH      = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  jk_reg_bank_if.slave        bus,
  output logic [CH*WIDTH-1:0] q
`ifdef JK_REG_BANK_EDGE_EN
  ,
  output logic [CH*WIDTH-1:0] rise,
  output logic [CH*WIDTH-1:0] fall
`endif
);

  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic [WIDTH-1:0] q_ch   [CH];
  logic [WIDTH-1:0] chg_ch [CH];
  logic [CH-1:0]    wr_sel;
  logic [CH-1:0]    rd_clr;
  logic             rd_hit;
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] rd_c;

  always_comb begin
    wr_sel = '0;
    rd_clr = '0;
    rd_hit = 1'b0;
    rd_q   = '0;
    rd_c   = '0;
    for (int c = 0; c < CH; c++) begin
      wr_sel[c] = bus.cmd_valid && (bus.cmd_ch == CHW'(c));
      rd_clr[c] = bus.rd_en && (bus.rd_ch == CHW'(c));
      if (bus.rd_ch == CHW'(c)) begin
        rd_hit = 1'b1;
        rd_q   = q_ch[c];
        rd_c   = chg_ch[c];
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    jk_reg_channel #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_sel (wr_sel[c]),
      .j      (bus.cmd_j),
      .k      (bus.cmd_k),
      .rd_clr (rd_clr[c]),
      .q      (q_ch[c]),
      .chg    (chg_ch[c])
`ifdef JK_REG_BANK_EDGE_EN
      ,
      .rise   (rise[c*WIDTH +: WIDTH]),
      .fall   (fall[c*WIDTH +: WIDTH])
`endif
    );
    assign q[c*WIDTH +: WIDTH] = q_ch[c];
  end

  // out-of-range reads still answer, with zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      bus.rd_chg   <= '0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_data <= rd_hit ? rd_q : '0;
        bus.rd_chg  <= rd_hit ? rd_c : '0;
      end
    end
  end

endmodule
